// File: rtl/calltrace_buf.sv
// calltrace_buf: shadow call stack / call-return log fed by the committed instruction stream
module calltrace_buf #(
   parameter int DEPTH = 32,
   parameter int AW    = 5,
   parameter int DW    = 24,
   parameter int MODE  = 0
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          exec,
   input  logic          taken,
   input  logic [31:0]   ir,
   input  logic [31:0]   lnk,
   input  logic          freeze,
   input  logic          clr,
   input  logic [AW-1:0] rd_idx,
   output logic [DW:0]   rd_data,
   output logic [AW:0]   count,
   output logic          ovf,
   output logic          udf
);
   logic [DW:0]   mem [DEPTH];
   logic [AW-1:0] wp;
   logic          pend_call, pend_ret, is_call, is_ret, push, pop, full;
   logic          unused;
   assign unused = ^{lnk[31:DW], ir[27:8]};
   // decode events now; the buffer acts on the previous cycle's pending event, when lnk holds the return address
   always_comb begin
      is_call = exec & taken & (ir[31:30] == 2'b11) & ir[28];
      is_ret  = exec & taken & (ir[31:28] == 4'b1100) & (ir[7:4] == 4'd0) & (ir[3:0] == 4'hf);
      push    = ~clr & (pend_call | ((MODE != 0) & pend_ret));
      pop     = ~clr & pend_ret & (MODE == 0);
      full    = count == (AW+1)'(DEPTH);
   end
   // pending stage, write pointer, occupancy, sticky flags and registered read port
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pend_call <= 1'b0;
         pend_ret  <= 1'b0;
         wp        <= '0;
         count     <= '0;
         ovf       <= 1'b0;
         udf       <= 1'b0;
         rd_data   <= '0;
      end else begin
         pend_call <= is_call & ~freeze & ~clr;
         pend_ret  <= is_ret & ~freeze & ~clr;
         rd_data   <= mem[wp - AW'(1) - rd_idx];
         if (clr) begin
            wp    <= '0;
            count <= '0;
            ovf   <= 1'b0;
            udf   <= 1'b0;
         end else if (push) begin
            wp <= wp + AW'(1);
            if (full) ovf <= 1'b1;
            else count <= count + (AW+1)'(1);
         end else if (pop) begin
            if (count == '0) udf <= 1'b1;
            else begin
               wp    <= wp - AW'(1);
               count <= count - (AW+1)'(1);
            end
         end
      end
   end
   // entry storage; the stack mode only ever holds calls, so its tag is constant 1
   always_ff @(posedge clk) begin
      if (push) mem[wp] <= {(MODE == 0) ? 1'b1 : pend_call, lnk[DW-1:0]};
   end
endmodule

// File: tb/tb_calltrace_buf.sv
// tb_calltrace_buf: scoreboard bench for three configurations against a queue-based model
module tb_calltrace_buf;
   typedef struct {
      logic        chk;
      logic [24:0] rd;
      int          cnt;
      logic        ovf;
      logic        udf;
   } exp_t;
   localparam int DEP [3] = '{32, 4, 8};
   localparam int MOD [3] = '{0, 0, 1};
   logic        clk = 1'b0, rst = 1'b1, exec = 1'b0, taken = 1'b0, freeze = 1'b0, clr = 1'b0;
   logic [31:0] ir = '0, lnk = '0;
   logic [4:0]  rd_idx = '0;
   logic [24:0] rd0, rd1, rd2;
   logic [5:0]  c0;
   logic [2:0]  c1;
   logic [3:0]  c2;
   logic        ovf_o [3], udf_o [3];
   logic [24:0] a_rd [3];
   logic [5:0]  a_cnt [3];
   exp_t        sb [3][$];
   logic [24:0] hist [3][$];
   logic        m_ovf [3], m_udf [3];
   int          pend = 0, checks = 0, errors = 0;

   calltrace_buf #(.DEPTH(32), .AW(5), .DW(24), .MODE(0)) u0 (.clk(clk), .rst(rst), .exec(exec), .taken(taken),
      .ir(ir), .lnk(lnk), .freeze(freeze), .clr(clr), .rd_idx(rd_idx), .rd_data(rd0), .count(c0), .ovf(ovf_o[0]), .udf(udf_o[0]));
   calltrace_buf #(.DEPTH(4), .AW(2), .DW(24), .MODE(0)) u1 (.clk(clk), .rst(rst), .exec(exec), .taken(taken),
      .ir(ir), .lnk(lnk), .freeze(freeze), .clr(clr), .rd_idx(rd_idx[1:0]), .rd_data(rd1), .count(c1), .ovf(ovf_o[1]), .udf(udf_o[1]));
   calltrace_buf #(.DEPTH(8), .AW(3), .DW(24), .MODE(1)) u2 (.clk(clk), .rst(rst), .exec(exec), .taken(taken),
      .ir(ir), .lnk(lnk), .freeze(freeze), .clr(clr), .rd_idx(rd_idx[2:0]), .rd_data(rd2), .count(c2), .ovf(ovf_o[2]), .udf(udf_o[2]));

   always #5 clk = ~clk;

   // uniform view of the three instances' outputs
   always_comb begin
      a_rd[0] = rd0;
      a_rd[1] = rd1;
      a_rd[2] = rd2;
      a_cnt[0] = c0;
      a_cnt[1] = {3'b0, c1};
      a_cnt[2] = {2'b0, c2};
   end

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s got %h exp %h at %0t", n, a, e, $time);
      end
   endtask

   // kind: 0 non-branch, 1 call, 2 return, 3 near-miss return (no event)
   function automatic logic [31:0] mk_ir(input int kind);
      logic [31:0] r;
      r = $urandom;
      case (kind)
         1: begin r[31:30] = 2'b11; r[28] = 1'b1; end
         2: begin r[31:28] = 4'hc; r[7:0] = 8'h0f; end
         3: begin r[31:28] = 4'hc; r[7:4] = 4'h0; r[3:0] = 4'($urandom_range(0, 14)); end
         default: r[31] = 1'b0;
      endcase
      return r;
   endfunction

   function automatic void model_reset();
      for (int i = 0; i < 3; i++) begin
         hist[i].delete();
         m_ovf[i] = 1'b0;
         m_udf[i] = 1'b0;
      end
      pend = 0;
   endfunction

   // one clock: apply inputs, then advance the model and queue the expected post-edge view
   task automatic cyc(input bit e, input bit t, input bit f, input bit c, input int kind, input logic [31:0] l, input int idx);
      exec = e; taken = t; freeze = f; clr = c; ir = mk_ir(kind); lnk = l; rd_idx = 5'(idx);
      @(posedge clk);
      for (int i = 0; i < 3; i++) begin
         exp_t x;
         int k;
         k = idx % DEP[i];
         x.chk = k < hist[i].size();
         x.rd = x.chk ? hist[i][k] : '0;
         if (c) begin
            hist[i].delete();
            m_ovf[i] = 1'b0;
            m_udf[i] = 1'b0;
         end else if (pend == 1 || (pend == 2 && MOD[i] == 1)) begin
            hist[i].push_front({(MOD[i] == 0 || pend == 1), l[23:0]});
            if (hist[i].size() > DEP[i]) begin
               void'(hist[i].pop_back());
               m_ovf[i] = 1'b1;
            end
         end else if (pend == 2) begin
            if (hist[i].size() > 0) void'(hist[i].pop_front());
            else m_udf[i] = 1'b1;
         end
         x.cnt = hist[i].size();
         x.ovf = m_ovf[i];
         x.udf = m_udf[i];
         sb[i].push_back(x);
      end
      pend = (e && t && !f && !c && (kind == 1 || kind == 2)) ? kind : 0;
      #1;
   endtask

   // monitor: compares each instance's registered outputs against the queued expectation
   always @(negedge clk) begin
      for (int i = 0; i < 3; i++) begin
         if (sb[i].size() > 0) begin
            exp_t x;
            x = sb[i].pop_front();
            chk($sformatf("count%0d", i), 32'(a_cnt[i]), 32'(x.cnt));
            chk($sformatf("ovf%0d", i), 32'(ovf_o[i]), 32'(x.ovf));
            chk($sformatf("udf%0d", i), 32'(udf_o[i]), 32'(x.udf));
            if (x.chk) chk($sformatf("rd%0d", i), 32'(a_rd[i]), 32'(x.rd));
         end
      end
   end

   initial begin
      model_reset();
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_cnt", 32'({c0, c1, c2}), 32'd0);
      chk("rst_flags", 32'({ovf_o[0], ovf_o[1], ovf_o[2], udf_o[0], udf_o[1], udf_o[2]}), 32'd0);
      chk("rst_rd", 32'(rd0 | rd1 | rd2), 32'd0);
      rst = 1'b1;
      for (int k = 0; k < 6; k++) cyc(1, 1, 0, 0, 1, 32'(k), 0);
      cyc(1, 1, 0, 0, 0, 32'd6, 0);
      chk("wrap_cnt4", 32'(c1), 32'd4);
      chk("wrap_ovf4", 32'(ovf_o[1]), 32'd1);
      chk("wrap_cnt32", 32'(c0), 32'd6);
      chk("wrap_ovf32", 32'(ovf_o[0]), 32'd0);
      for (int k = 0; k < 4; k++) begin
         cyc(0, 0, 0, 0, 0, 32'h0, k);
         chk("wrap_rd4", 32'(rd1), 32'h1000000 | 32'(6 - k));
      end
      cyc(0, 0, 0, 1, 0, 32'h0, 0);
      cyc(1, 1, 0, 0, 1, 32'h0, 0);
      cyc(1, 1, 0, 0, 1, 32'h100, 0);
      cyc(1, 1, 0, 0, 1, 32'h200, 0);
      cyc(1, 1, 0, 0, 0, 32'h300, 0);
      chk("stack_cnt", 32'(c0), 32'd3);
      for (int k = 0; k < 3; k++) begin
         cyc(0, 0, 0, 0, 0, 32'h0, k);
         chk("stack_rd", 32'(rd0), 32'h1000300 - 32'(k * 'h100));
      end
      cyc(1, 1, 0, 0, 2, 32'h0, 0);
      cyc(1, 1, 0, 0, 0, 32'h0, 0);
      cyc(0, 0, 0, 0, 0, 32'h0, 0);
      chk("pop_cnt", 32'(c0), 32'd2);
      chk("pop_rd", 32'(rd0), 32'h1000200);
      chk("pop_flags", 32'({ovf_o[0], udf_o[0]}), 32'd0);
      cyc(0, 0, 0, 1, 0, 32'h0, 0);
      cyc(1, 1, 0, 0, 2, 32'h0, 0);
      cyc(1, 1, 0, 0, 0, 32'h55, 0);
      chk("udf_cnt", 32'(c0), 32'd0);
      chk("udf_set", 32'(udf_o[0]), 32'd1);
      chk("log_no_udf", 32'({c2, udf_o[2]}), 32'b10);
      cyc(1, 1, 0, 0, 1, 32'h0, 0);
      cyc(1, 1, 0, 0, 0, 32'h77, 0);
      chk("udf_sticky", 32'({c0, udf_o[0]}), 32'b11);
      cyc(0, 1, 0, 0, 1, 32'h1, 0);
      cyc(1, 0, 0, 0, 1, 32'h2, 0);
      cyc(1, 1, 1, 0, 1, 32'h3, 0);
      cyc(1, 1, 0, 0, 3, 32'h4, 0);
      cyc(1, 1, 0, 0, 0, 32'h5, 0);
      chk("ignored_cnt", 32'(c0), 32'd1);
      cyc(1, 1, 0, 0, 1, 32'h6, 0);
      cyc(1, 1, 0, 1, 0, 32'h7, 0);
      cyc(0, 0, 0, 0, 0, 32'h8, 0);
      chk("clr_kill", 32'({c0, c1, c2}), 32'd0);
      cyc(1, 1, 0, 0, 1, 32'h0, 0);
      cyc(1, 1, 0, 0, 2, 32'h40, 0);
      cyc(1, 1, 0, 0, 0, 32'h40, 0);
      chk("log_cnt", 32'(c2), 32'd2);
      cyc(0, 0, 0, 0, 0, 32'h0, 0);
      chk("log_rd0", 32'(rd2), 32'h0000040);
      cyc(0, 0, 0, 0, 0, 32'h0, 1);
      chk("log_rd1", 32'(rd2), 32'h1000040);
      cyc(1, 1, 0, 0, 1, 32'h0, 0);
      @(negedge clk);
      #1 rst = 1'b0;
      #1;
      chk("mid_rst_cnt", 32'({c0, c1, c2}), 32'd0);
      chk("mid_rst_misc", 32'({rd0, ovf_o[2], udf_o[0]}), 32'd0);
      model_reset();
      #1 rst = 1'b1;
      cyc(0, 0, 0, 0, 0, 32'h99, 0);
      cyc(0, 0, 0, 0, 0, 32'h99, 0);
      chk("mid_rst_nowrite", 32'({c0, c1, c2}), 32'd0);
      for (int n = 0; n < 600; n++)
         cyc($urandom_range(0, 7) != 0, $urandom_range(0, 3) != 0, $urandom_range(0, 7) == 0,
             $urandom_range(0, 39) == 0, $urandom_range(0, 3), $urandom, $urandom_range(0, 31));
      @(negedge clk);
      #1;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
